retire_rob: RTL and testbench
=============================

RETIRE_ROB -- requirements
Module: retire_rob

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16: number of reorder-buffer entries; must be a power of two and at least 4.
REQ-002 SHALL have parameter TAG_W, default $clog2(ROB_DEPTH): ROB tag width.
REQ-003 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_alloc_valid[0:1]  in  1 each  renamed instruction present in slot.
REQ-006 SHALL have port i_alloc_pdst[0:1]  in  p_reg  new destination PReg; 0 = no destination.
REQ-007 SHALL have port i_alloc_old_pdst[0:1]  in  p_reg  previous mapping of that AReg; 0 = none.
REQ-008 SHALL have port o_alloc_ready  out  1  two or more entries free.
REQ-009 SHALL have port o_alloc_tag[0:1]  out  TAG_W each  tag assigned to each slot this cycle.
REQ-010 SHALL have port i_cmpl_valid[0:1] / i_cmpl_tag[0:1]  in  1 / TAG_W each  execution-complete reports.
REQ-011 SHALL have port o_free_PRegs[0:1]  out  p_reg each  PRegs returned to the rename free pool; 0 = none.
REQ-012 SHALL have port o_retire_valid[0:1]  out  1 each  slot retired last cycle.
REQ-013 SHALL have port o_count  out  TAG_W+1  occupied entries.

Function
REQ-014 SHALL keep head, tail (TAG_W bits, wrap modulo ROB_DEPTH) and count; per entry: valid, done, pdst, old_pdst.
REQ-015 SHALL derive o_alloc_ready combinationally from registered count: count <= ROB_DEPTH-2; retirements in the same cycle give no credit.
REQ-016 SHALL drive o_alloc_tag[0] = tail and o_alloc_tag[1] = tail+1 when slot 0 is valid; a lone valid slot 1 SHALL be packed to tail.
REQ-017 SHALL accept valid slots only while o_alloc_ready=1, writing valid=1 and done=0; inputs are ignored while ready is 0.
REQ-018 SHALL set done for each valid completion whose tag addresses a valid entry; completions to invalid entries are ignored. Two completions to the same tag are harmless.
REQ-019 SHALL retire slot 0 when entry[head] is valid and done, using registered state only. Slot 1 (head+1) SHALL retire only if slot 0 retires and entry[head+1] is valid and done (strict program order).
REQ-020 SHALL register o_free_PRegs[i] = old_pdst of the retired entry, and o_retire_valid[i]=1, one cycle after the retire decision; non-retiring slots output 0. A retired old_pdst of 0 outputs 0.
REQ-021 SHALL invalidate retired entries, advance head by the number retired, and update count = count + allocated - retired in one edge.
REQ-022 An entry completed at edge N SHALL retire at edge N+1 at the earliest, with o_free_PRegs visible after edge N+1.
REQ-023 Full (count=ROB_DEPTH): ready=0, retire proceeds. Empty: no retirement. Pointer wrap from ROB_DEPTH-1 to 0 SHALL be seamless.

Reset
REQ-024 SHALL, on i_rst_n low, asynchronously clear head, tail, count, all valid/done bits, o_free_PRegs, o_retire_valid and the statistics counter. o_alloc_ready SHALL then read 1. Reset mid-operation discards all entries.

Configuration
REQ-025 With RETIRE_ROB_STATS_EN defined, SHALL add output o_retired_total (32 bits), incremented by the retire count each cycle and wrapping at 2^32. Without the macro, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-026 p_reg, ROB_DEPTH default and a rob_entry_t struct SHALL live in package Types; the retire-select logic SHALL be sub-module retire_rob_select (head entries in, retire count out).

Verification
REQ-027 After reset, allocate pdst 33/34 with old 5/6, then complete both -> o_free_PRegs = {5,6} with both retire_valid=1 two edges after completion.
REQ-028 Complete tag 1 before tag 0 -> no retire until tag 0 completes; then both retire in the same cycle, in order.
REQ-029 Fill 16 entries -> o_alloc_ready=0 at count 15; further alloc ignored; o_count stays 16.
REQ-030 Run 40 alloc/complete/retire pairs -> tags wrap 15->0, and the freed PReg sequence matches the allocation order.
REQ-031 Pulse i_rst_n low with 7 entries live -> o_count=0, outputs 0, ready=1; stale completions are ignored.
REQ-032 With RETIRE_ROB_STATS_EN, after 10 retirements -> o_retired_total=10.

Source files
------------

// File: rtl/retire_rob_pkg.sv
// Shared types for the retire reorder buffer: physical register tag, default depth
// and the per-entry record.
package Types;

  localparam int ROB_DEPTH_DEFAULT = 16;
  localparam int PREG_W            = 7;

  typedef logic [PREG_W-1:0] p_reg;

  typedef struct packed {
    logic valid;
    logic done;
    p_reg pdst;
    p_reg old_pdst;
  } rob_entry_t;

endpackage

// File: rtl/retire_rob_select.sv
// In-order retire selection over the two oldest ROB entries; slot 1 may only retire
// behind slot 0. Yields the retire count and the PRegs to free.
module retire_rob_select
  import Types::*;
(
  input  rob_entry_t head_e   [0:1],
  output logic       ret_vld  [0:1],
  output p_reg       ret_preg [0:1],
  output logic [1:0] ret_cnt
);

  // The new mapping is not needed to retire; only the previous mapping is freed.
  logic pdst_unused;
  assign pdst_unused = ^{head_e[0].pdst, head_e[1].pdst};

  always_comb begin
    ret_vld[0]  = head_e[0].valid & head_e[0].done;
    ret_vld[1]  = ret_vld[0] & head_e[1].valid & head_e[1].done;
    ret_preg[0] = ret_vld[0] ? head_e[0].old_pdst : '0;
    ret_preg[1] = ret_vld[1] ? head_e[1].old_pdst : '0;
    ret_cnt     = {1'b0, ret_vld[0]} + {1'b0, ret_vld[1]};
  end

endmodule

// File: rtl/retire_rob.sv
// Two-wide allocate/complete/retire reorder buffer returning old PRegs to rename.
// Optional build macro RETIRE_ROB_STATS_EN adds the o_retired_total counter port.
module retire_rob
  import Types::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_alloc_valid    [0:1],
  input  p_reg             i_alloc_pdst     [0:1],
  input  p_reg             i_alloc_old_pdst [0:1],
  output logic             o_alloc_ready,
  output logic [TAG_W-1:0] o_alloc_tag      [0:1],
  input  logic             i_cmpl_valid     [0:1],
  input  logic [TAG_W-1:0] i_cmpl_tag       [0:1],
  output p_reg             o_free_PRegs     [0:1],
  output logic             o_retire_valid   [0:1],
  output logic [TAG_W:0]   o_count
`ifdef RETIRE_ROB_STATS_EN
  ,
  output logic [31:0]      o_retired_total
`endif
);

  logic [TAG_W-1:0]     head_q, tail_q;
  logic [TAG_W:0]       count_q;
  logic [ROB_DEPTH-1:0] valid_q, done_q;
  p_reg                 pdst_q [ROB_DEPTH];
  p_reg                 old_q  [ROB_DEPTH];

  logic                 wr_en    [0:1];
  logic [TAG_W-1:0]     head_idx [0:1];
  logic [1:0]           n_alloc;
  rob_entry_t           head_e   [0:1];
  logic                 ret_vld  [0:1];
  p_reg                 ret_preg [0:1];
  logic [1:0]           ret_cnt;
  logic                 ret_vld_p1  [0:1];
  p_reg                 free_p1     [0:1];

  // Credit comes only from registered occupancy, never from same-cycle retirement.
  assign o_alloc_ready  = (count_q <= (TAG_W+1)'(ROB_DEPTH - 2));
  assign o_alloc_tag[0] = tail_q;
  assign o_alloc_tag[1] = i_alloc_valid[0] ? tail_q + TAG_W'(1) : tail_q;

  assign wr_en[0]    = o_alloc_ready & i_alloc_valid[0];
  assign wr_en[1]    = o_alloc_ready & i_alloc_valid[1];
  assign n_alloc     = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
  assign head_idx[0] = head_q;
  assign head_idx[1] = head_q + TAG_W'(1);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head_e[i].valid    = valid_q[head_idx[i]];
      head_e[i].done     = done_q[head_idx[i]];
      head_e[i].pdst     = pdst_q[head_idx[i]];
      head_e[i].old_pdst = old_q[head_idx[i]];
    end
  end

  retire_rob_select u_select (
    .head_e   (head_e),
    .ret_vld  (ret_vld),
    .ret_preg (ret_preg),
    .ret_cnt  (ret_cnt)
  );

  // Stage p0 -> p1: control state update and registered retire outputs.
  // Later writes win: completion < allocation < retire invalidation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      ret_vld_p1 <= '{default: 1'b0};
      free_p1    <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i_cmpl_valid[i] && valid_q[i_cmpl_tag[i]]) done_q[i_cmpl_tag[i]] <= 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          valid_q[o_alloc_tag[i]] <= 1'b1;
          done_q[o_alloc_tag[i]]  <= 1'b0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (ret_vld[i]) begin
          valid_q[head_idx[i]] <= 1'b0;
          done_q[head_idx[i]]  <= 1'b0;
        end
      end
      tail_q     <= tail_q + TAG_W'(n_alloc);
      head_q     <= head_q + TAG_W'(ret_cnt);
      count_q    <= count_q + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(ret_cnt);
      ret_vld_p1 <= ret_vld;
      free_p1    <= ret_preg;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        pdst_q[o_alloc_tag[i]] <= i_alloc_pdst[i];
        old_q[o_alloc_tag[i]]  <= i_alloc_old_pdst[i];
      end
    end
  end

  assign o_retire_valid = ret_vld_p1;
  assign o_free_PRegs   = free_p1;
  assign o_count        = count_q;

`ifdef RETIRE_ROB_STATS_EN
  logic [31:0] total_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) total_q <= '0;
    else          total_q <= total_q + 32'(ret_cnt);
  end

  assign o_retired_total = total_q;
`endif

endmodule

// File: tb/tb_retire_rob.sv
// Scoreboard bench for retire_rob: freed PRegs are checked in allocation order by a
// monitor; occupancy, tags and retire timing are checked by directed steps.
module tb_retire_rob;
  import Types::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       alloc_valid [0:1];
  p_reg       alloc_pdst  [0:1];
  p_reg       alloc_old   [0:1];
  logic       ready;
  logic [3:0] alloc_tag   [0:1];
  logic       cmpl_valid  [0:1];
  logic [3:0] cmpl_tag    [0:1];
  p_reg       free_pregs  [0:1];
  logic       ret_valid   [0:1];
  logic [4:0] count;
`ifdef RETIRE_ROB_STATS_EN
  logic [31:0] retired_total;
`endif

  int         total = 0;
  int         bad   = 0;
  p_reg       exp_q[$];
  logic [3:0] exp_tail = '0;

  always #5 i_clk = ~i_clk;

  retire_rob #(.ROB_DEPTH(16)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_alloc_valid    (alloc_valid),
    .i_alloc_pdst     (alloc_pdst),
    .i_alloc_old_pdst (alloc_old),
    .o_alloc_ready    (ready),
    .o_alloc_tag      (alloc_tag),
    .i_cmpl_valid     (cmpl_valid),
    .i_cmpl_tag       (cmpl_tag),
    .o_free_PRegs     (free_pregs),
    .o_retire_valid   (ret_valid),
    .o_count          (count)
`ifdef RETIRE_ROB_STATS_EN
    ,
    .o_retired_total  (retired_total)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic alloc(input bit v0, input p_reg pd0, input p_reg od0,
                       input bit v1, input p_reg pd1, input p_reg od1, input bit accept);
    alloc_valid[0] = v0; alloc_pdst[0] = pd0; alloc_old[0] = od0;
    alloc_valid[1] = v1; alloc_pdst[1] = pd1; alloc_old[1] = od1;
    #1;
    if (accept) begin
      chk("alloc_ready", 32'(ready), 32'd1);
      if (v0) begin
        chk("alloc_tag0", 32'(alloc_tag[0]), 32'(exp_tail));
        exp_q.push_back(od0);
        exp_tail++;
      end
      if (v1) begin
        chk("alloc_tag1", 32'(alloc_tag[1]), 32'(exp_tail));
        exp_q.push_back(od1);
        exp_tail++;
      end
    end else begin
      chk("alloc_ready_low", 32'(ready), 32'd0);
    end
    tick();
    alloc_valid[0] = 1'b0;
    alloc_valid[1] = 1'b0;
  endtask

  task automatic complete(input logic [3:0] t0, input bit v0, input logic [3:0] t1, input bit v1);
    cmpl_valid[0] = v0; cmpl_tag[0] = t0;
    cmpl_valid[1] = v1; cmpl_tag[1] = t1;
    tick();
    cmpl_valid[0] = 1'b0;
    cmpl_valid[1] = 1'b0;
  endtask

  // Monitor: every retirement must free the next PReg in allocation order.
  always @(negedge i_clk) begin
    p_reg p;
    if (ret_valid[1] === 1'b1 && ret_valid[0] !== 1'b1) begin
      total++; bad++;
      $display("FAIL retire_order: slot1 retired without slot0 at %0t", $time);
    end
    for (int i = 0; i < 2; i++) begin
      if (ret_valid[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_retire: slot %0d freed %0d, nothing expected at %0t",
                   i, free_pregs[i], $time);
        end else begin
          p = exp_q.pop_front();
          chk($sformatf("free_preg%0d", i), 32'(free_pregs[i]), 32'(p));
        end
      end else if (i_rst_n === 1'b1) begin
        chk($sformatf("idle_free%0d", i), 32'(free_pregs[i]), 32'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      alloc_valid[i] = 1'b0; alloc_pdst[i] = '0; alloc_old[i] = '0;
      cmpl_valid[i]  = 1'b0; cmpl_tag[i]   = '0;
    end
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_ret0", 32'(ret_valid[0]), 32'd0);
    chk("reset_free0", 32'(free_pregs[0]), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Basic pair: free {5,6} two edges after completion.
    alloc(1, 7'd33, 7'd5, 1, 7'd34, 7'd6, 1);
    chk("pair_count", 32'(count), 32'd2);
    complete(4'd0, 1, 4'd1, 1);
    chk("pair_no_early_retire", 32'(ret_valid[0]), 32'd0);
    tick();
    chk("pair_ret0", 32'(ret_valid[0]), 32'd1);
    chk("pair_ret1", 32'(ret_valid[1]), 32'd1);
    chk("pair_count_after", 32'(count), 32'd0);

    // Out-of-order completion waits for the head.
    alloc(1, 7'd40, 7'd7, 1, 7'd41, 7'd8, 1);
    complete(4'd3, 1, 4'd0, 0);
    chk("ooo_wait_a", 32'(ret_valid[0]), 32'd0);
    tick();
    chk("ooo_wait_b", 32'(ret_valid[0]), 32'd0);
    chk("ooo_count", 32'(count), 32'd2);
    complete(4'd2, 1, 4'd0, 0);
    chk("ooo_wait_c", 32'(ret_valid[0]), 32'd0);
    tick();
    chk("ooo_ret0", 32'(ret_valid[0]), 32'd1);
    chk("ooo_ret1", 32'(ret_valid[1]), 32'd1);

    // Lone slot 1 packs to tail; old_pdst 0 frees 0.
    alloc(0, 7'd0, 7'd0, 1, 7'd50, 7'd0, 1);
    complete(4'd0, 0, 4'd4, 1);
    tick();
    chk("lone_ret0", 32'(ret_valid[0]), 32'd1);
    chk("lone_ret1", 32'(ret_valid[1]), 32'd0);

    // Fill to full, ignore extra allocs, retire while full.
    for (int k = 0; k < 8; k++)
      alloc(1, 7'(60 + 2*k), 7'(10 + 2*k), 1, 7'(61 + 2*k), 7'(11 + 2*k), 1);
    chk("full_count", 32'(count), 32'd16);
    chk("full_ready", 32'(ready), 32'd0);
    alloc(1, 7'd99, 7'd99, 1, 7'd98, 7'd98, 0);
    chk("full_count_hold", 32'(count), 32'd16);
    complete(4'd5, 1, 4'd0, 0);
    tick();
    chk("c15_count", 32'(count), 32'd15);
    chk("c15_ready", 32'(ready), 32'd0);
    for (int t = 0; t < 8; t++) complete(4'(2*t), 1, 4'(2*t + 1), 1);
    repeat (4) tick();
    chk("drain_count", 32'(count), 32'd0);

    // 40 back-to-back pairs, tags wrap repeatedly.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] t0, t1;
      t0 = exp_tail;
      t1 = exp_tail + 4'd1;
      alloc(1, 7'(k + 1), 7'(30 + (2*k) % 90), 1, 7'(k + 2), 7'(31 + (2*k) % 90), 1);
      complete(t0, 1, t1, 1);
    end
    repeat (3) tick();
    chk("stream_count", 32'(count), 32'd0);

    // Reset with 7 live entries discards them.
    for (int k = 0; k < 3; k++)
      alloc(1, 7'(70 + k), 7'(90 + k), 1, 7'(80 + k), 7'(100 + k), 1);
    alloc(1, 7'd77, 7'd110, 0, 7'd0, 7'd0, 1);
    chk("live7_count", 32'(count), 32'd7);
    i_rst_n = 1'b0;
    #1;
    chk("mid_reset_count", 32'(count), 32'd0);
    chk("mid_reset_ready", 32'(ready), 32'd1);
    chk("mid_reset_ret1", 32'(ret_valid[1]), 32'd0);
    chk("mid_reset_free1", 32'(free_pregs[1]), 32'd0);
    exp_q.delete();
    exp_tail = '0;
    #2;
    i_rst_n = 1'b1;
    tick();
`ifdef RETIRE_ROB_STATS_EN
    chk("stats_reset", retired_total, 32'd0);
`endif
    complete(4'd5, 1, 4'd6, 1);
    complete(4'd7, 1, 4'd8, 1);
    complete(4'd9, 1, 4'd10, 1);
    tick();
    chk("stale_count", 32'(count), 32'd0);
    chk("stale_ret0", 32'(ret_valid[0]), 32'd0);

    // Five fresh pairs after reset: tags restart at 0, ten retirements.
    for (int k = 0; k < 5; k++) begin
      logic [3:0] t0, t1;
      t0 = exp_tail;
      t1 = exp_tail + 4'd1;
      alloc(1, 7'(20 + k), 7'(40 + 2*k), 1, 7'(21 + k), 7'(41 + 2*k), 1);
      complete(t0, 1, t1, 1);
    end
    repeat (3) tick();
    chk("post_reset_count", 32'(count), 32'd0);
`ifdef RETIRE_ROB_STATS_EN
    chk("stats_total", retired_total, 32'd10);
`endif
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
